// File: rtl/if_id_pipe.sv
// IF->ID pipeline register with a 2-entry skid buffer, stall/flush handling
// and saturating stall/flush performance counters.
module if_id_pipe #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_exc,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              exc;
  } entry_t;

  localparam entry_t           EMPTY   = '{1'b0, {ADDR_W{1'b0}}, NOP_INST, 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  entry_t           r_m;
  entry_t           r_s;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  entry_t w_in;
  entry_t w_m_nxt;
  entry_t w_s_nxt;
  logic   w_acc;
  logic   w_pop;

  // Transfer happens on either side only when valid and ready are both high in
  // the same cycle; stall masks the decode-side ready, in_ready is ~S.valid
  // taken from a flop so upstream never sees a combinational path.
  assign w_acc = in_valid & r_in_ready;
  assign w_pop = r_m.valid & out_ready & ~stall;
  assign w_in  = '{1'b1, in_pc, in_inst, in_exc};

  always_comb begin
    w_m_nxt = r_m;
    w_s_nxt = r_s;
    if (flush) begin
      w_m_nxt = EMPTY;
      w_s_nxt = EMPTY;
    end else if (!r_m.valid) begin
      if (w_acc) w_m_nxt = w_in;
    end else if (!r_s.valid) begin
      if (w_pop) w_m_nxt = w_acc ? w_in : EMPTY;
      else if (w_acc) w_s_nxt = w_in;
    end else if (w_pop) begin
      w_m_nxt = r_s;
      w_s_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m            <= EMPTY;
      r_s            <= EMPTY;
      r_in_ready     <= 1'b1;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_m        <= w_m_nxt;
      r_s        <= w_s_nxt;
      r_in_ready <= ~w_s_nxt.valid;
      if (!flush && r_m.valid && !w_pop && r_stall_cycles != CNT_MAX)
        r_stall_cycles <= r_stall_cycles + CNT_ONE;
      // An empty flush with nothing arriving has no architectural effect.
      if (flush && (r_m.valid || r_s.valid || w_acc) && r_flush_count != CNT_MAX)
        r_flush_count <= r_flush_count + CNT_ONE;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_m.valid;
  assign out_pc       = r_m.pc;
  assign out_inst     = r_m.inst;
  assign out_exc      = r_m.exc;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: vector tables, hand sequences and a FIFO scoreboard
// checking every popped entry against what was accepted.
module tb_if_id_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic        in_valid, in_ready, in_exc;
  logic [31:0] in_pc, in_inst;
  logic        out_valid, out_ready, out_exc;
  logic [31:0] out_pc, out_inst;
  logic        stall, flush;
  logic [15:0] stall_cycles, flush_count;

  logic        s_in_ready, s_out_valid, s_out_exc;
  logic [31:0] s_out_pc, s_out_inst;
  logic [3:0]  s_stall_cycles, s_flush_count;

  if_id_pipe #(.ADDR_W(32), .INST_W(32), .NOP_INST(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc),
    .stall(stall), .flush(flush), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  if_id_pipe #(.ADDR_W(32), .INST_W(32), .NOP_INST(NOP), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_inst(in_inst), .in_exc(in_exc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_inst(s_out_inst), .out_exc(s_out_exc),
    .stall(stall), .flush(flush), .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int pop_cnt = 0;
  logic [64:0] exp_q[$];
  logic [64:0] sb_e;

  typedef struct {
    logic iv; logic [31:0] pc; logic ordy; logic stl; logic fl;
    logic ev; logic [31:0] epc; logic eir; logic [15:0] esc; logic [15:0] efc;
  } vec_t;

  vec_t bp_tab[6];
  vec_t fl_tab[6];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // driver tasks
  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic exc, input logic ordy, input logic stl, input logic fl);
    in_valid = iv; in_pc = pc; in_inst = inst; in_exc = exc;
    out_ready = ordy; stall = stl; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 32'h100, inst_of(32'h100), 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, NOP);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_stall_cycles", stall_cycles, 16'd0);
    check("rst_flush_count", flush_count, 16'd0);
    rst = 1'b0;
    exp_q.delete();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_row(input vec_t v, input string tag);
    drive(v.iv, v.pc, inst_of(v.pc), 1'b0, v.ordy, v.stl, v.fl);
    tick();
    check({tag, "_out_valid"}, out_valid, v.ev);
    check({tag, "_out_pc"}, out_pc, v.epc);
    check({tag, "_out_inst"}, out_inst, v.ev ? inst_of(v.epc) : NOP);
    check({tag, "_in_ready"}, in_ready, v.eir);
    check({tag, "_stall_cycles"}, stall_cycles, v.esc);
    check({tag, "_flush_count"}, flush_count, v.efc);
  endtask

  // scoreboard: sampled on the falling edge, before the transfer edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready && !stall) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          sb_e = exp_q.pop_front();
          check("sb_pc", out_pc, sb_e[64:33]);
          check("sb_inst", out_inst, sb_e[32:1]);
          check("sb_exc", out_exc, sb_e[0]);
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_pc, in_inst, in_exc});
      if (flush) exp_q.delete();
    end
  end

  initial begin
    //               iv    pc        ordy  stl   fl    ev    epc       eir   esc    efc
    bp_tab[0] = '{1'b1, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 16'd0, 16'd0};
    bp_tab[1] = '{1'b1, 32'h04, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 16'd1, 16'd0};
    bp_tab[2] = '{1'b1, 32'h08, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 16'd2, 16'd0};
    bp_tab[3] = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 1'b1, 32'h04, 1'b1, 16'd2, 16'd0};
    bp_tab[4] = '{1'b1, 32'h08, 1'b1, 1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 16'd2, 16'd0};
    bp_tab[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 16'd2, 16'd0};

    fl_tab[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 16'd0, 16'd0};
    fl_tab[1] = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 16'd1, 16'd0};
    fl_tab[2] = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 16'd1, 16'd1};
    fl_tab[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 16'd1, 16'd1};
    fl_tab[4] = '{1'b1, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 16'd1, 16'd2};
    fl_tab[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 16'd1, 16'd2};

    do_reset();

    // streaming, one entry per cycle
    pop_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4 * i), inst_of(32'(4 * i)), 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check("stream_out_valid", out_valid, 1'b1);
      check("stream_out_pc", out_pc, 32'(4 * i));
      check("stream_in_ready", in_ready, 1'b1);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stream_drained", out_valid, 1'b0);
    check("stream_pops", pop_cnt, 8);
    check("stream_stall_cycles", stall_cycles, 16'd0);

    do_reset();
    for (int i = 0; i < 6; i++) run_row(bp_tab[i], "skid");
    check("skid_sb_empty", exp_q.size(), 0);

    // stall holds the head entry steady
    do_reset();
    drive(1'b1, 32'h40, 32'h8C01_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_out_pc", out_pc, 32'h40);
      check("stall_out_inst", out_inst, 32'h8C01_0000);
      check("stall_out_valid", out_valid, 1'b1);
    end
    check("stall_count", stall_cycles, 16'd3);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stall_release_valid", out_valid, 1'b0);
    check("stall_release_count", stall_cycles, 16'd3);

    do_reset();
    for (int i = 0; i < 6; i++) run_row(fl_tab[i], "flush");

    // saturation and exception passthrough
    do_reset();
    drive(1'b1, 32'h20, inst_of(32'h20), 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("exc_pc", out_pc, 32'h20);
    check("exc_flag", out_exc, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_4bit", s_stall_cycles, 4'hF);
    check("sat_stall_16bit", stall_cycles, 16'd20);
    drive(1'b1, 32'h24, inst_of(32'h24), 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("exc_next_pc", out_pc, 32'h24);
    check("exc_next_flag", out_exc, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("exc_drained", out_valid, 1'b0);
    check("final_sb_empty", exp_q.size(), 0);

    // reset while an entry is held
    drive(1'b1, 32'h30, inst_of(32'h30), 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("midrst_loaded", out_valid, 1'b1);
    do_reset();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
